registered_stream_mux: RTL and testbench

REGISTERED_STREAM_MUX -- requirements
Module: registered_stream_mux

---
 rtl/mux_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/registered_stream_mux.sv | 120 ++++++++++++
 tb/tb_registered_stream_mux.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and types for the registered stream multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  function automatic int sel_width(input int channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting channel at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    idx,
  output logic                any
);

  int               pos;
  logic [SEL_W-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    k     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pos = int'(ptr) + i;
      if (pos >= CHANNELS) pos = pos - CHANNELS;
      k = SEL_W'(pos);
      if (!any && req[k]) begin
        any      = 1'b1;
        idx      = k;
        grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/registered_stream_mux.sv
// N-to-1 stream mux with fixed or round-robin selection and a single
// full-throughput output register.
module registered_stream_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_load,
  output logic                      sel_err,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  out_state_t       state_p1, state_nxt;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] chan_p1;
  logic [SEL_W-1:0] sel_reg, ptr;
  logic             err_p1;

  logic [WIDTH-1:0]    ch_data [CHANNELS];
  logic [CHANNELS-1:0] rr_grant;
  logic [SEL_W-1:0]    rr_idx;
  logic                rr_any;
  logic [SEL_W-1:0]    cand;
  logic                load_en, xfer, vld_p1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Stage 0: candidate selection and combinational handshake
  always_comb begin
    cand     = sel_reg;
    in_ready = '0;
    if (mode == MODE_RR) begin
      cand = rr_idx;
      if (load_en) in_ready = rr_grant;
    end else if (load_en) begin
      in_ready = CHANNELS'(1) << sel_reg;
    end
    if (!rst_n) in_ready = '0;
  end

  assign xfer = |(in_valid & in_ready);

  // Stage 1: output register state machine
  always_ff @(posedge clk) begin
    if (!rst_n) state_p1 <= ST_EMPTY;
    else        state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      ST_EMPTY: if (xfer)               state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !xfer) state_nxt = ST_EMPTY;
      default:                          state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    vld_p1  = (state_p1 == ST_FULL);
    load_en = !vld_p1 || out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p1 <= '0;
      chan_p1 <= '0;
    end else if (xfer) begin
      data_p1 <= ch_data[cand];
      chan_p1 <= cand;
    end
  end

  // Out-of-range selects are rejected; the old select stays in force.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_reg <= '0;
      ptr     <= '0;
      err_p1  <= 1'b0;
    end else begin
      err_p1 <= 1'b0;
      if (sel_load) begin
        if (int'(sel) < CHANNELS) sel_reg <= sel;
        else                      err_p1  <= 1'b1;
      end
      if (xfer && mode == MODE_RR)
        ptr <= (rr_idx == SEL_W'(CHANNELS - 1)) ? '0 : rr_idx + 1'b1;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_chan  = chan_p1;
  assign sel_err   = err_p1;

endmodule

// File: tb/tb_registered_stream_mux.sv
// Directed and randomized checks of registered_stream_mux against a queue-free
// behavioural model; a 5-channel instance covers out-of-range selects.
module tb_registered_stream_mux;
  import mux_pkg::*;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int SW  = 2;
  localparam int CH5 = 5;
  localparam int SW5 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid, in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic            sel_load, sel_err;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid, out_ready;

  logic             rst5_n;
  logic [CH5*W-1:0] in_data5;
  logic [CH5-1:0]   in_valid5, in_ready5;
  logic             mode5;
  logic [SW5-1:0]   sel5;
  logic             sel_load5, sel_err5;
  logic [W-1:0]     out_data5;
  logic [SW5-1:0]   out_chan5;
  logic             out_valid5, out_ready5;

  registered_stream_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .sel_load(sel_load),
    .sel_err(sel_err), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  registered_stream_mux #(.WIDTH(W), .CHANNELS(CH5)) dut5 (
    .clk(clk), .rst_n(rst5_n), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .mode(mode5), .sel(sel5), .sel_load(sel_load5),
    .sel_err(sel_err5), .out_data(out_data5), .out_chan(out_chan5),
    .out_valid(out_valid5), .out_ready(out_ready5)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for the 4-channel instance
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_chan  = 0;
  int           m_sel   = 0;
  int           m_ptr   = 0;
  logic         m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] exp_rdy();
    int k;
    if (!rst_n) return '0;
    if (m_valid && !out_ready) return '0;
    if (mode == MODE_FIXED) return CH'(1) << m_sel;
    for (int i = 0; i < CH; i++) begin
      k = (m_ptr + i) % CH;
      if (in_valid[k]) return CH'(1) << k;
    end
    return '0;
  endfunction

  task automatic model_edge(input logic [CH-1:0] rdy);
    int g;
    logic [CH-1:0] hit;
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_chan = 0; m_sel = 0; m_ptr = 0; m_err = 1'b0;
      return;
    end
    hit = in_valid & rdy;
    g = 0;
    for (int i = 0; i < CH; i++) if (hit[i]) g = i;
    m_err = 1'b0;
    if (sel_load) begin
      if (int'(sel) < CH) m_sel = int'(sel);
      else                m_err = 1'b1;
    end
    if (hit != '0) begin
      m_data  = in_data[g*W +: W];
      m_chan  = g;
      m_valid = 1'b1;
      if (mode == MODE_RR) m_ptr = (g + 1) % CH;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic cycle();
    logic [CH-1:0] er;
    #1;
    er = exp_rdy();
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    model_edge(er);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_chan", 32'(out_chan), 32'(m_chan));
    chk("sel_err", 32'(sel_err), 32'(m_err));
    @(negedge clk);
  endtask

  task automatic cycle5();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  function automatic logic [CH*W-1:0] rand_data();
    logic [CH*W-1:0] d;
    for (int i = 0; i < CH; i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; mode = MODE_FIXED;
    sel = '0; sel_load = 1'b0; out_ready = 1'b0;
    rst5_n = 1'b0; in_data5 = '0; in_valid5 = '0; mode5 = MODE_FIXED;
    sel5 = '0; sel_load5 = 1'b0; out_ready5 = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);

    // Fixed select of channel 2
    rst_n = 1'b1; sel = 2'd2; sel_load = 1'b1; out_ready = 1'b1;
    cycle();
    sel_load = 1'b0; in_valid = 4'b1111;
    in_data = rand_data(); in_data[2*W +: W] = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      chk("fix_ready", 32'(in_ready), 32'h4);
      cycle();
      chk("fix_data", 32'(out_data), 32'hA5);
      chk("fix_chan", 32'(out_chan), 32'd2);
    end

    // Round-robin over all valid channels from ptr 0
    mode = MODE_RR;
    for (int i = 0; i < 8; i++) begin
      in_data = rand_data();
      cycle();
      chk("rr_seq_chan", 32'(out_chan), 32'(i % CH));
    end

    // Sparse requests with wrap: ptr moved to 1 first
    in_valid = 4'b0001;
    cycle();
    in_valid = 4'b1001;
    cycle(); chk("rr_wrap_a", 32'(out_chan), 32'd3);
    cycle(); chk("rr_wrap_b", 32'(out_chan), 32'd0);
    cycle(); chk("rr_wrap_c", 32'(out_chan), 32'd3);

    // Back-pressure hold
    mode = MODE_FIXED; in_valid = 4'b0100;
    in_data = rand_data(); in_data[2*W +: W] = 8'h3C;
    cycle();
    chk("hold_load", 32'(out_data), 32'h3C);
    out_ready = 1'b0; sel = 2'd1; sel_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = rand_data(); in_valid = CH'($urandom); mode = i[0];
      #1 chk("hold_ready", 32'(in_ready), 32'd0);
      cycle();
      chk("hold_data", 32'(out_data), 32'h3C);
    end
    out_ready = 1'b1; sel_load = 1'b0; mode = MODE_FIXED; in_valid = 4'b0010;
    in_data = rand_data(); in_data[1*W +: W] = 8'h5A;
    cycle();
    chk("release_data", 32'(out_data), 32'h5A);
    chk("release_chan", 32'(out_chan), 32'd1);

    // Reset while full, then round-robin restarts at channel 0
    out_ready = 1'b0;
    rst_n = 1'b0;
    cycle();
    chk("rst_full_valid", 32'(out_valid), 32'd0);
    chk("rst_full_data", 32'(out_data), 32'd0);
    rst_n = 1'b1; mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
    cycle();
    chk("rst_rr_chan", 32'(out_chan), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom % 50) != 0;
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      sel_load  = ($urandom % 4) == 0;
      in_valid  = CH'($urandom);
      in_data   = rand_data();
      out_ready = ($urandom % 3) != 0;
      cycle();
    end

    // Out-of-range selects on a 5-channel instance
    cycle5();
    rst5_n = 1'b1; out_ready5 = 1'b1; sel5 = 3'd4; sel_load5 = 1'b1;
    cycle5();
    chk("sel5_ok_err", 32'(sel_err5), 32'd0);
    sel5 = 3'd5;
    cycle5();
    chk("sel5_err_pulse", 32'(sel_err5), 32'd1);
    sel_load5 = 1'b0; in_valid5 = 5'b10000; in_data5 = '0; in_data5[4*W +: W] = 8'h77;
    #1 chk("sel5_ready", 32'(in_ready5), 32'h10);
    cycle5();
    chk("sel5_err_clear", 32'(sel_err5), 32'd0);
    chk("sel5_data", 32'(out_data5), 32'h77);
    chk("sel5_chan", 32'(out_chan5), 32'd4);
    sel5 = 3'd7; sel_load5 = 1'b1;
    cycle5();
    chk("sel7_err_pulse", 32'(sel_err5), 32'd1);
    sel_load5 = 1'b0;
    #1 chk("sel7_ready", 32'(in_ready5), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
